// File: rtl/connector_pkg.sv
// connector_pkg: shared types for the commit serializer and its FIFO
package connector_pkg;
  localparam int XLEN = 32;
  localparam int SKIP_CNT_W = 16;
  typedef enum logic [3:0] {
    FU_ADD, FU_SUB, FU_LOAD, FU_STORE, FU_BRANCH, FU_JAL, FU_JALR, FU_CSR
  } fu_op;
  typedef enum logic [2:0] {NoCF, Branch, Jump, JumpR, Return} cf_t;
  typedef struct packed {
    logic [XLEN-1:0]       pc;
    fu_op                  op;
    cf_t                   cf_type;
    logic                  branch_taken;
    logic                  exception;
    logic                  interrupt;
    logic [SKIP_CNT_W-1:0] skip_cnt;
  } commit_entry_t;
  function automatic logic [SKIP_CNT_W-1:0] sat_inc(input logic [SKIP_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/connector_fifo.sv
// connector_fifo: multi-push single-pop FIFO of commit entries, push count selects how many of data_i are written
module connector_fifo import connector_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int MAX_PUSH = 3,
  localparam int AW = $clog2(DEPTH),
  localparam int CNT_W = $clog2(MAX_PUSH + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [CNT_W-1:0]             push_cnt_i,
  input  commit_entry_t [MAX_PUSH-1:0] data_i,
  input  logic                         pop_i,
  output commit_entry_t                head_o,
  output logic                         empty_o,
  output logic [AW:0]                  usage_o
);
  commit_entry_t mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] usage;
  logic pop;
  assign empty_o = usage == '0;
  assign usage_o = usage;
  assign head_o = mem[rptr];
  assign pop = pop_i && !empty_o;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      usage <= '0;
    end else begin
      for (int i = 0; i < MAX_PUSH; i++)
        if (i < int'(push_cnt_i)) mem[wptr + AW'(i)] <= data_i[i];
      wptr <= wptr + AW'(push_cnt_i);
      rptr <= rptr + AW'(pop);
      usage <= usage + (AW+1)'(push_cnt_i) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/commit_serializer.sv
// commit_serializer: packs per-cycle commit groups into a FIFO for itype detection.
// Optional CONNECTOR_COMMIT_FILTER_EN drops plain instructions and counts them in skip_cnt.
module commit_serializer import connector_pkg::*; #(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NR_COMMIT_PORTS-1:0]            valid_i,
  input  logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]  pc_i,
  input  fu_op [NR_COMMIT_PORTS-1:0]            op_i,
  input  cf_t  [NR_COMMIT_PORTS-1:0]            cf_type_i,
  input  logic [NR_COMMIT_PORTS-1:0]            branch_taken_i,
  input  logic                                  exception_i,
  input  logic                                  interrupt_i,
  input  logic                                  ready_i,
  output logic                                  stall_o,
  output logic                                  overflow_o,
  output logic                                  valid_o,
  output logic [XLEN-1:0]                       pc_o,
  output fu_op                                  op_o,
  output cf_t                                   cf_type_o,
  output logic                                  branch_taken_o,
  output logic                                  exception_o,
  output logic                                  interrupt_o,
  output logic [SKIP_CNT_W-1:0]                 skip_cnt_o
);
  localparam int MAX_PUSH = NR_COMMIT_PORTS + 1;
  localparam int CNT_W = $clog2(MAX_PUSH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  commit_entry_t [MAX_PUSH-1:0] grp;
  commit_entry_t e, head, out;
  logic [CNT_W-1:0] n, push_cnt;
  logic [AW:0] usage, free_now, free;
  logic empty, pop, fits, keep, filt, overflow_q;
  int k;
`ifdef CONNECTOR_COMMIT_FILTER_EN
  logic [SKIP_CNT_W-1:0] run, acc, skip_q;
`endif
  always_comb begin
    grp = '0;
    e = '0;
    k = 0;
    keep = 1'b0;
    filt = 1'b0;
`ifdef CONNECTOR_COMMIT_FILTER_EN
    run = skip_q;
    acc = skip_q;
`endif
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      keep = exception_i ? (i == 0) : valid_i[i];
      e = '0;
      e.pc = pc_i[i];
      e.op = op_i[i];
      e.cf_type = cf_type_i[i];
      e.branch_taken = branch_taken_i[i];
      e.exception = exception_i;
      filt = 1'b0;
`ifdef CONNECTOR_COMMIT_FILTER_EN
      filt = keep && cf_type_i[i] == NoCF && !exception_i && !interrupt_i;
      if (filt) begin
        run = sat_inc(run);
        acc = sat_inc(acc);
      end else if (keep) begin
        e.skip_cnt = run;
        run = '0;
      end
`endif
      if (keep && !filt) begin
        grp[k] = e;
        k = k + 1;
      end
    end
    if (interrupt_i) begin
      e = '0;
      e.interrupt = 1'b1;
`ifdef CONNECTOR_COMMIT_FILTER_EN
      e.skip_cnt = run;
      run = '0;
`endif
      grp[k] = e;
      k = k + 1;
    end
    n = CNT_W'(k);
  end
  // room freed by this cycle's pop counts toward admitting the group
  assign free_now = (AW+1)'(FIFO_DEPTH) - usage;
  assign free = free_now + (AW+1)'(pop);
  assign fits = (AW+1)'(n) <= free;
  assign push_cnt = fits ? n : '0;
  assign valid_o = rst_ni && !empty;
  assign pop = valid_o && ready_i;
  assign stall_o = rst_ni && free_now < (AW+1)'(MAX_PUSH);
  assign overflow_o = rst_ni && overflow_q;
  assign out = valid_o ? head : '0;
  assign pc_o = out.pc;
  assign op_o = out.op;
  assign cf_type_o = out.cf_type;
  assign branch_taken_o = out.branch_taken;
  assign exception_o = out.exception;
  assign interrupt_o = out.interrupt;
  assign skip_cnt_o = out.skip_cnt;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) overflow_q <= 1'b0;
    else if (n != '0 && !fits) overflow_q <= 1'b1;
  end
`ifdef CONNECTOR_COMMIT_FILTER_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) skip_q <= '0;
    else skip_q <= fits ? run : acc;
  end
`endif
  connector_fifo #(.DEPTH(FIFO_DEPTH), .MAX_PUSH(MAX_PUSH)) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_cnt_i (push_cnt),
    .data_i     (grp),
    .pop_i      (pop),
    .head_o     (head),
    .empty_o    (empty),
    .usage_o    (usage)
  );
endmodule

// File: tb/tb_commit_serializer.sv
// tb_commit_serializer: directed vectors with hand-computed expectations for commit_serializer
module tb_commit_serializer;
  import connector_pkg::*;
  logic clk = 1'b0, rst_ni = 1'b0;
  logic [1:0] valid_i = '0, branch_taken_i = '0;
  logic [1:0][XLEN-1:0] pc_i = '0;
  fu_op [1:0] op_i;
  cf_t [1:0] cf_type_i;
  logic exception_i = 1'b0, interrupt_i = 1'b0, ready_i = 1'b0;
  logic stall_o, overflow_o, valid_o, branch_taken_o, exception_o, interrupt_o;
  logic [XLEN-1:0] pc_o;
  fu_op op_o;
  cf_t cf_type_o;
  logic [SKIP_CNT_W-1:0] skip_cnt_o;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  commit_serializer dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .pc_i(pc_i), .op_i(op_i),
    .cf_type_i(cf_type_i), .branch_taken_i(branch_taken_i), .exception_i(exception_i),
    .interrupt_i(interrupt_i), .ready_i(ready_i), .stall_o(stall_o), .overflow_o(overflow_o),
    .valid_o(valid_o), .pc_o(pc_o), .op_o(op_o), .cf_type_o(cf_type_o),
    .branch_taken_o(branch_taken_o), .exception_o(exception_o), .interrupt_o(interrupt_o),
    .skip_cnt_o(skip_cnt_o)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [1:0] v, input logic [XLEN-1:0] p0, input logic [XLEN-1:0] p1, input cf_t cf);
    valid_i = v;
    pc_i[0] = p0;
    pc_i[1] = p1;
    cf_type_i[0] = cf;
    cf_type_i[1] = cf;
  endtask
  initial begin
    op_i[0] = FU_BRANCH;
    op_i[1] = FU_BRANCH;
    cf_type_i[0] = Branch;
    cf_type_i[1] = Branch;
    drive(2'b11, 32'hdead, 32'hbeef, Branch);
    step();
    step();
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    chk("rst_pc", 64'(pc_o), 64'd0);
    chk("rst_skip", 64'(skip_cnt_o), 64'd0);
    rst_ni = 1'b1;
    ready_i = 1'b1;
    drive(2'b11, 32'h100, 32'h104, Branch);
    chk("no_bypass", 64'(valid_o), 64'd0);
    step();
    drive(2'b11, 32'h108, 32'h10c, Branch);
    chk("pair_v0", 64'(valid_o), 64'd1);
    chk("pair_pc0", 64'(pc_o), 64'h100);
    step();
    drive(2'b00, 0, 0, Branch);
    chk("pair_pc1", 64'(pc_o), 64'h104);
    step();
    chk("pushpop_pc2", 64'(pc_o), 64'h108);
    step();
    chk("pushpop_pc3", 64'(pc_o), 64'h10c);
    step();
    chk("drain_empty", 64'(valid_o), 64'd0);
    drive(2'b11, 32'h200, 32'h204, Branch);
    exception_i = 1'b1;
    step();
    drive(2'b00, 0, 0, Branch);
    exception_i = 1'b0;
    chk("exc_pc", 64'(pc_o), 64'h200);
    chk("exc_flag", 64'(exception_o), 64'd1);
    step();
    chk("exc_single", 64'(valid_o), 64'd0);
    drive(2'b01, 32'h300, 0, NoCF);
    op_i[0] = FU_SUB;
    interrupt_i = 1'b1;
    step();
    drive(2'b00, 0, 0, Branch);
    interrupt_i = 1'b0;
    chk("irq_ins_pc", 64'(pc_o), 64'h300);
    chk("irq_ins_op", 64'(op_o), 64'(FU_SUB));
    chk("irq_ins_flag", 64'(interrupt_o), 64'd0);
    step();
    chk("irq_flag", 64'(interrupt_o), 64'd1);
    chk("irq_pc", 64'(pc_o), 64'd0);
    chk("irq_op", 64'(op_o), 64'(FU_ADD));
    step();
    chk("irq_empty", 64'(valid_o), 64'd0);
    op_i[0] = FU_BRANCH;
    ready_i = 1'b0;
    drive(2'b11, 32'h400, 32'h404, Branch);
    chk("fill_stall0", 64'(stall_o), 64'd0);
    step();
    chk("fill_stall2", 64'(stall_o), 64'd0);
    step();
    chk("fill_stall4", 64'(stall_o), 64'd0);
    step();
    chk("fill_stall6", 64'(stall_o), 64'd1);
    step();
    chk("fill_ovf8", 64'(overflow_o), 64'd0);
    chk("fill_hold_pc", 64'(pc_o), 64'h400);
    step();
    chk("fill_drop_ovf", 64'(overflow_o), 64'd1);
    chk("fill_drop_stall", 64'(stall_o), 64'd1);
    drive(2'b00, 0, 0, Branch);
    ready_i = 1'b1;
    step();
    step();
    step();
    ready_i = 1'b0;
    chk("drain_pc", 64'(pc_o), 64'h404);
    chk("drain_stall", 64'(stall_o), 64'd0);
    chk("ovf_sticky", 64'(overflow_o), 64'd1);
`ifdef CONNECTOR_COMMIT_FILTER_EN
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    ready_i = 1'b1;
    drive(2'b11, 32'h10, 32'h14, NoCF);
    step();
    drive(2'b01, 32'h18, 0, NoCF);
    step();
    chk("filt_none", 64'(valid_o), 64'd0);
    drive(2'b01, 32'h300, 0, Branch);
    branch_taken_i = 2'b01;
    step();
    drive(2'b00, 0, 0, Branch);
    branch_taken_i = 2'b00;
    ready_i = 1'b0;
    chk("filt_pc", 64'(pc_o), 64'h300);
    chk("filt_skip", 64'(skip_cnt_o), 64'd3);
    chk("filt_taken", 64'(branch_taken_o), 64'd1);
    drive(2'b11, 32'h600, 32'h604, Branch);
    step();
    step();
    drive(2'b00, 0, 0, Branch);
`endif
    drive(2'b11, 32'h700, 32'h704, Branch);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    drive(2'b00, 0, 0, Branch);
    chk("rst2_valid", 64'(valid_o), 64'd0);
    chk("rst2_ovf", 64'(overflow_o), 64'd0);
    chk("rst2_stall", 64'(stall_o), 64'd0);
    drive(2'b11, 32'h500, 32'h504, Branch);
    step();
    drive(2'b00, 0, 0, Branch);
    ready_i = 1'b1;
    chk("rst2_pc0", 64'(pc_o), 64'h500);
    step();
    chk("rst2_pc1", 64'(pc_o), 64'h504);
    step();
    chk("rst2_empty", 64'(valid_o), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/commit_serializer.md
COMMIT_SERIALIZER -- requirements
Module: commit_serializer

Interface
REQ-001 SHALL have parameter NR_COMMIT_PORTS, default 2: number of commit ports sampled per cycle.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: number of entries; power of two, at least NR_COMMIT_PORTS+1.
REQ-003 clk_i  in  1  the only clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1  reset; synchronous and active-low.
REQ-005 valid_i  in  NR_COMMIT_PORTS  per-port commit valid.
REQ-006 pc_i  in  NR_COMMIT_PORTS x connector_pkg::XLEN  per-port committed PC.
REQ-007 op_i  in  NR_COMMIT_PORTS x connector_pkg::fu_op  per-port functional-unit operation.
REQ-008 cf_type_i  in  NR_COMMIT_PORTS x connector_pkg::cf_t  per-port control-flow type.
REQ-009 branch_taken_i  in  NR_COMMIT_PORTS  per-port branch or jump taken.
REQ-010 exception_i  in  1  exception on port 0 this cycle.
REQ-011 interrupt_i  in  1  interrupt taken this cycle.
REQ-012 stall_o  out  1  upstream hold request: fewer than NR_COMMIT_PORTS+1 free entries.
REQ-013 overflow_o  out  1  sticky flag: a commit group was dropped.
REQ-014 valid_o, pc_o, op_o, cf_type_o, branch_taken_o, exception_o, interrupt_o  out  entry fields  head entry presented to the itype detection stage.
REQ-015 skip_cnt_o  out  16  number of plain instructions filtered before the head entry.
REQ-016 ready_i  in  1  downstream accepts the head entry.

Function
REQ-017 SHALL build one commit group per cycle.
REQ-018 Commit group SHALL contain the valid ports in ascending port order.
REQ-019 When exception_i=1, the group SHALL be a single port-0 entry with exception=1; other ports are ignored.
REQ-020 When interrupt_i=1, one entry with interrupt=1, pc=0 and op=0 SHALL be appended after that cycle's instruction entries.
REQ-021 The group SHALL be written in one cycle only if free entries >= group size.
REQ-022 Free entries SHALL include any pop in the same cycle.
REQ-023 If the group does not fit, the entire group SHALL be dropped and overflow_o set.
REQ-024 overflow_o SHALL remain set until reset.
REQ-025 An entry written in cycle t SHALL appear on valid_o at cycle t+1 at the earliest; there is no bypass.
REQ-026 valid_o SHALL be 1 exactly when the FIFO is not empty.
REQ-027 The head SHALL pop when valid_o and ready_i are both 1.
REQ-028 While valid_o=1 and ready_i=0, all outputs SHALL stay stable.
REQ-029 Push and pop in the same cycle SHALL both take effect.
REQ-030 Occupancy SHALL never exceed FIFO_DEPTH.
REQ-031 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 stall_o SHALL be computed combinationally from the registered occupancy only, excluding the current pop.

Reset
REQ-033 While rst_ni=0 at a clock edge, the FIFO SHALL empty, pointers SHALL be cleared to 0 and overflow_o SHALL be cleared.
REQ-034 During and after reset, valid_o=0, stall_o=0, and every other output SHALL be 0.
REQ-035 A reset during traffic SHALL discard all stored entries and the filter counter.
REQ-036 Inputs presented while rst_ni=0 SHALL be ignored.

Configuration
REQ-037 With CONNECTOR_COMMIT_FILTER_EN defined, a valid instruction SHALL not be stored when cf_type is NoCF and neither exception nor interrupt is set.
REQ-038 With the macro defined, each filtered instruction SHALL increment a 16-bit saturating counter.
REQ-039 With the macro defined, the counter value SHALL be stored in the next stored entry as skip_cnt, then cleared in the same cycle.
REQ-040 With the macro defined, filtered instructions dropped by overflow SHALL still be counted.
REQ-041 Without the macro, every valid instruction SHALL be stored and skip_cnt_o SHALL be tied to 0.

Structure
REQ-042 connector_pkg SHALL hold XLEN, fu_op, cf_t, a commit_entry_t struct (pc, op, cf_type, branch_taken, exception, interrupt, skip_cnt), and SKIP_CNT_W=16.
REQ-043 Storage SHALL be one sub-module, connector_fifo: a multi-push single-pop FIFO of commit_entry_t with a push count input.

Verification
REQ-044 Ports 0 and 1 valid with pc 0x100/0x104, ready_i=1 -> valid_o for two consecutive cycles, 0x100 then 0x104.
REQ-045 exception_i=1 with both ports valid (0x200/0x204) -> single entry pc 0x200, exception_o=1; no 0x204.
REQ-046 One plain instruction, interrupt_i=1 -> instruction entry, then an entry with interrupt_o=1 and pc_o=0.
REQ-047 ready_i=0, groups of 2 each cycle, FIFO_DEPTH=8 -> stall_o=1 at occupancy 6; 5th group dropped; overflow_o=1 until reset.
REQ-048 Macro defined; 3 NoCF instructions, then a taken branch at 0x300 -> one entry, skip_cnt_o=3, branch_taken_o=1.
REQ-049 rst_ni=0 for one cycle with 5 entries stored -> next cycle valid_o=0, overflow_o=0, new pushes accepted.
